// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction-side front end for the RV32I core.
//
// It issues word fetches to instruction memory and buffers the returned
// words, each with its PC, in a prefetch FIFO. The FIFO head goes to decode
// through a valid/ready handshake. When decode consumes a branch, JAL or JALR,
// the fetch stream moves to the new target. Any responses still in flight at
// that point are dropped as they arrive.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   imem_req_valid/addr/ready   word fetch request (addr[1:0] always 0)
//   imem_resp_valid/data        in-order read data, one per accepted request
//   inst_valid/inst/inst_pc     FIFO head presented to decode
//   inst_ready                  decode consumes the head this cycle
//   pc_src                      00 seq, 01 branch/JAL, 10 JALR, 11 seq
//   target_br, target_jalr      redirect targets (low two bits ignored)
//
// state | meaning
// IDLE  | just out of reset, nothing issued yet
// RUN   | normal fetching, credit-limited by DEPTH
// FLUSH | redirect taken, discarding stale in-flight responses
module inst_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic [1:0]        pc_src,
  input  logic [ADDR_W-1:0] target_br,
  input  logic [ADDR_W-1:0] target_jalr
);

  localparam int unsigned       PTR_W   = $clog2(DEPTH);
  localparam int unsigned       CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_M = ~ADDR_W'(3);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]       fifo_data_q [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];

  logic [CNT_W:0]    credit_used;
  logic              pop, redirect, req_fire, resp_ok, resp_push;
  logic [ADDR_W-1:0] new_pc;

  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q] : '0;

  assign pop      = inst_valid & inst_ready;
  assign redirect = pop & ((pc_src == 2'b01) | (pc_src == 2'b10));
  assign new_pc   = ((pc_src == 2'b01) ? target_br : target_jalr) & ALIGN_M;

  // Requests in flight plus buffered words never exceed DEPTH, so the FIFO
  // always has room for every response that comes back.
  assign credit_used    = {1'b0, outst_q} + {1'b0, count_q};
  assign imem_req_valid = (state_q == S_RUN) && (credit_used < DEPTH_C) && !redirect;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok   = imem_resp_valid & (outst_q != '0);
  assign resp_push = resp_ok & (drop_q == '0) & !redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (req_fire) begin
      outst_d    = outst_d + 1'b1;
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
    if (resp_ok) begin
      outst_d = outst_d - 1'b1;
    end
    if (resp_ok && (drop_q != '0)) begin
      drop_d = drop_q - 1'b1;
    end
    if (resp_push) begin
      resp_pc_d = resp_pc_q + PC_STEP;
      wr_ptr_d  = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({resp_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // No request fires in a redirect cycle, so outst_d at this point is the
    // outstanding count less any response arriving now. That is exactly the
    // number of stale words still to come.
    if (redirect) begin
      fetch_pc_d = new_pc;
      resp_pc_d  = new_pc;
      count_d    = '0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = wr_ptr_q;
      drop_d     = outst_d;
    end

    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   if (redirect && (drop_d != '0)) state_d = S_FLUSH;
      S_FLUSH: if (drop_d == '0) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the head is gated by inst_valid.
  always_ff @(posedge clk) begin
    if (!rst && resp_push) begin
      fifo_data_q[wr_ptr_q] <= imem_resp_data;
      fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  localparam int          AW       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [1:0]  pc_src;
  logic [31:0] target_br;
  logic [31:0] target_jalr;

  inst_fetch_unit #(.ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .pc_src(pc_src),
    .target_br(target_br), .target_jalr(target_jalr)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = 1;
  bit resp_hold = 1'b0;

  // Memory model: pending accepted addresses with the step they may answer.
  logic [31:0] mem_q[$];
  int          elig_q[$];

  logic        obs_req_valid, obs_acc, obs_inst_valid, obs_pop, obs_resp;
  logic [31:0] obs_req_addr, obs_inst, obs_inst_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  // One clock: inputs already set at the negedge by the caller.
  task automatic step();
    logic do_resp;
    do_resp = 1'b0;
    if (!resp_hold && mem_q.size() > 0 && cyc >= elig_q[0]) do_resp = 1'b1;
    imem_resp_valid = do_resp;
    imem_resp_data  = do_resp ? mem_word(mem_q[0]) : $urandom;
    #1;
    obs_req_valid  = imem_req_valid;
    obs_req_addr   = imem_req_addr;
    obs_acc        = imem_req_valid & imem_req_ready;
    obs_inst_valid = inst_valid;
    obs_inst       = inst;
    obs_inst_pc    = inst_pc;
    obs_pop        = inst_valid & inst_ready;
    obs_resp       = do_resp;
    @(posedge clk);
    if (rst) begin
      mem_q.delete();
      elig_q.delete();
    end else begin
      if (do_resp) begin
        void'(mem_q.pop_front());
        void'(elig_q.pop_front());
      end
      if (obs_acc) begin
        mem_q.push_back(obs_req_addr);
        elig_q.push_back(cyc + lat);
      end
    end
    cyc++;
    @(negedge clk);
    imem_resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_req_ready = 1'b0;
    inst_ready = 1'b0;
    pc_src = 2'b00;
    resp_hold = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inst_ready = 1'b0;
    pc_src = 2'b00;
    imem_req_ready = 1'b1;
    step();
    step();
    n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    n_tests++; if (imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_req_addr: got %h expected %h", imem_req_addr, RESET_PC); end
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
    n_tests++; if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h expected 0", inst); end
    n_tests++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h expected 0", inst_pc); end
    rst = 1'b0;
    #1;
    n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL idle_req_valid: got %b expected 0", imem_req_valid); end
    @(negedge clk);
  endtask

  task automatic test_seq_run();
    int first_acc, first_val, n_acc, n_val;
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1; inst_ready = 1'b1; pc_src = 2'b00;
    first_acc = -1; first_val = -1; n_acc = 0; n_val = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (obs_acc) begin
        if (n_acc < 3) begin
          n_tests++; if (obs_req_addr !== RESET_PC + 32'(4 * n_acc)) begin n_fail++; $display("FAIL seq_req_addr: got %h expected %h", obs_req_addr, RESET_PC + 32'(4 * n_acc)); end
          if (n_acc == 0) first_acc = k;
          else begin
            n_tests++; if (k != first_acc + n_acc) begin n_fail++; $display("FAIL seq_req_consec: got step %0d expected %0d", k, first_acc + n_acc); end
          end
        end
        n_acc++;
      end
      if (obs_inst_valid) begin
        if (first_val < 0) begin
          first_val = k;
          n_tests++; if (k - first_acc != 2) begin n_fail++; $display("FAIL seq_latency: got %0d expected 2", k - first_acc); end
        end
        if (n_val < 6) begin
          n_tests++; if (obs_inst_pc !== RESET_PC + 32'(4 * n_val)) begin n_fail++; $display("FAIL seq_inst_pc: got %h expected %h", obs_inst_pc, RESET_PC + 32'(4 * n_val)); end
          n_tests++; if (obs_inst !== mem_word(RESET_PC + 32'(4 * n_val))) begin n_fail++; $display("FAIL seq_inst: got %h expected %h", obs_inst, mem_word(RESET_PC + 32'(4 * n_val))); end
          n_tests++; if (k != first_val + n_val) begin n_fail++; $display("FAIL seq_rate: got step %0d expected %0d", k, first_val + n_val); end
        end
        n_val++;
      end
    end
    n_tests++; if (n_val < 6) begin n_fail++; $display("FAIL seq_count: got %0d expected >=6", n_val); end
  endtask

  task automatic test_backpressure();
    int n_acc, n_val;
    bit got_next;
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1; inst_ready = 1'b0; pc_src = 2'b00;
    n_acc = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (obs_acc) begin
        n_tests++; if (obs_req_addr !== 32'(4 * n_acc)) begin n_fail++; $display("FAIL bp_req_addr: got %h expected %h", obs_req_addr, 32'(4 * n_acc)); end
        n_acc++;
      end
    end
    n_tests++; if (n_acc != DEPTH) begin n_fail++; $display("FAIL bp_accepts: got %0d expected %0d", n_acc, DEPTH); end
    n_tests++; if (obs_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_stalled: got %b expected 0", obs_req_valid); end
    inst_ready = 1'b1;
    n_val = 0; got_next = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (obs_pop && n_val < 4) begin
        n_tests++; if (obs_inst_pc !== 32'(4 * n_val)) begin n_fail++; $display("FAIL bp_inst_pc: got %h expected %h", obs_inst_pc, 32'(4 * n_val)); end
        n_val++;
      end
      if (obs_acc && !got_next) begin
        got_next = 1'b1;
        n_tests++; if (obs_req_addr !== 32'h10) begin n_fail++; $display("FAIL bp_resume_addr: got %h expected 00000010", obs_req_addr); end
      end
    end
    n_tests++; if (n_val != 4 || !got_next) begin n_fail++; $display("FAIL bp_drain: got %0d pops resume=%0d expected 4 pops resume=1", n_val, got_next); end
  endtask

  task automatic test_branch();
    bit found, seen_req, seen_inst;
    int stale_left, left;
    do_reset();
    lat = 3;
    imem_req_ready = 1'b1; inst_ready = 1'b1; pc_src = 2'b00;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (inst_valid === 1'b1 && inst_pc === 32'h8) begin found = 1'b1; break; end
      step();
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL br_reach_head: got none expected inst_pc 00000008"); end
    pc_src = 2'b01; target_br = 32'h40; target_jalr = 32'hDEAD_BEEC;
    resp_hold = 1'b1;
    stale_left = mem_q.size();
    step();
    n_tests++; if (obs_req_valid !== 1'b0) begin n_fail++; $display("FAIL br_req_forced_off: got %b expected 0", obs_req_valid); end
    pc_src = 2'b00; resp_hold = 1'b0;
    seen_req = 1'b0; seen_inst = 1'b0;
    for (int k = 0; k < 40 && !(seen_req && seen_inst); k++) begin
      left = stale_left;
      step();
      if (obs_resp && stale_left > 0) stale_left--;
      if (left > 0) begin
        n_tests++; if (obs_req_valid !== 1'b0) begin n_fail++; $display("FAIL br_flush_no_req: got %b expected 0", obs_req_valid); end
      end else if (!seen_req) begin
        seen_req = 1'b1;
        n_tests++; if (obs_req_valid !== 1'b1 || obs_req_addr !== 32'h40) begin n_fail++; $display("FAIL br_first_req: got %b/%h expected 1/00000040", obs_req_valid, obs_req_addr); end
      end
      if (obs_inst_valid && !seen_inst) begin
        seen_inst = 1'b1;
        n_tests++; if (obs_inst_pc !== 32'h40) begin n_fail++; $display("FAIL br_next_pc: got %h expected 00000040", obs_inst_pc); end
        n_tests++; if (obs_inst !== mem_word(32'h40)) begin n_fail++; $display("FAIL br_next_inst: got %h expected %h", obs_inst, mem_word(32'h40)); end
      end
    end
    n_tests++; if (!(seen_req && seen_inst)) begin n_fail++; $display("FAIL br_timeout: got req=%0d inst=%0d expected 1/1", seen_req, seen_inst); end
  endtask

  task automatic test_jalr_same_cycle();
    bit found, seen;
    logic [31:0] head;
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1; inst_ready = 1'b1; pc_src = 2'b00;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (inst_valid === 1'b1 && inst_pc === 32'h10) begin found = 1'b1; break; end
      step();
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL jalr_reach_head: got none expected inst_pc 00000010"); end
    pc_src = 2'b10; target_jalr = 32'h103; target_br = 32'h0000_0F00;
    step();
    n_tests++; if (!obs_resp || obs_req_valid !== 1'b0) begin n_fail++; $display("FAIL jalr_redirect_cycle: got resp=%0d req_valid=%b expected 1/0", obs_resp, obs_req_valid); end
    pc_src = 2'b00;
    step();
    n_tests++; if (obs_req_valid !== 1'b1 || obs_req_addr !== 32'h100) begin n_fail++; $display("FAIL jalr_next_req: got %b/%h expected 1/00000100", obs_req_valid, obs_req_addr); end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (inst_valid === 1'b1) begin
        seen = 1'b1;
        head = inst_pc;
        n_tests++; if (inst_pc !== 32'h100) begin n_fail++; $display("FAIL jalr_inst_pc: got %h expected 00000100", inst_pc); end
        n_tests++; if (inst !== mem_word(32'h100)) begin n_fail++; $display("FAIL jalr_inst: got %h expected %h", inst, mem_word(32'h100)); end
        pc_src = 2'b11; target_br = 32'h800; target_jalr = 32'h900;
        step();
        pc_src = 2'b00;
        n_tests++; if (inst_valid !== 1'b1 || inst_pc !== head + 32'h4) begin n_fail++; $display("FAIL pcsrc11_no_redirect: got %b/%h expected 1/%h", inst_valid, inst_pc, head + 32'h4); end
      end else begin
        step();
      end
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL jalr_timeout: got none expected inst_pc 00000100"); end
  endtask

  task automatic test_reset_mid();
    int n_resp;
    bit found, seen;
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1; inst_ready = 1'b0; pc_src = 2'b00;
    n_resp = 0; found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (n_resp == 3 && mem_q.size() == 1) begin found = 1'b1; break; end
      step();
      if (obs_resp) n_resp++;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL rstmid_setup: got %0d resp expected 3 buffered 1 outstanding", n_resp); end
    rst = 1'b1;
    step();
    n_tests++; if (!obs_resp) begin n_fail++; $display("FAIL rstmid_late_resp: got 0 expected response during reset"); end
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_inst_valid: got %b expected 0", inst_valid); end
    n_tests++; if (imem_req_addr !== RESET_PC || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got %b/%h expected 0/%h", imem_req_valid, imem_req_addr, RESET_PC); end
    rst = 1'b0; inst_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (obs_inst_valid) begin
        seen = 1'b1;
        n_tests++; if (obs_inst_pc !== RESET_PC || obs_inst !== mem_word(RESET_PC)) begin n_fail++; $display("FAIL rstmid_restart: got %h/%h expected %h/%h", obs_inst_pc, obs_inst, RESET_PC, mem_word(RESET_PC)); end
      end
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL rstmid_timeout: got none expected restart at %h", RESET_PC); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, prev_addr;
    bit prev_stall, redir;
    int n_cons, r;
    do_reset();
    lat = $urandom_range(1, 3);
    exp_pc = RESET_PC; prev_stall = 1'b0; prev_addr = '0; n_cons = 0;
    for (int k = 0; k < 1500; k++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 3) != 0);
      resp_hold      = ($urandom_range(0, 4) == 0);
      r = $urandom_range(0, 9);
      pc_src = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
      target_br = $urandom; target_jalr = $urandom;
      step();
      redir = obs_pop && (pc_src == 2'b01 || pc_src == 2'b10);
      if (prev_stall && !redir) begin
        n_tests++; if (obs_req_valid !== 1'b1 || obs_req_addr !== prev_addr) begin n_fail++; $display("FAIL rnd_req_stable: got %b/%h expected 1/%h", obs_req_valid, obs_req_addr, prev_addr); end
      end
      if (obs_req_valid) begin
        n_tests++; if (obs_req_addr[1:0] !== 2'b00) begin n_fail++; $display("FAIL rnd_req_align: got %h expected low bits 00", obs_req_addr); end
      end
      n_tests++; if (mem_q.size() > DEPTH) begin n_fail++; $display("FAIL rnd_credit: got %0d outstanding expected <=%0d", mem_q.size(), DEPTH); end
      if (obs_pop) begin
        n_tests++; if (obs_inst_pc !== exp_pc) begin n_fail++; $display("FAIL rnd_inst_pc: got %h expected %h", obs_inst_pc, exp_pc); end
        n_tests++; if (obs_inst !== mem_word(exp_pc)) begin n_fail++; $display("FAIL rnd_inst: got %h expected %h", obs_inst, mem_word(exp_pc)); end
        n_cons++;
        if (pc_src == 2'b01)      exp_pc = target_br & ~32'h3;
        else if (pc_src == 2'b10) exp_pc = target_jalr & ~32'h3;
        else                      exp_pc = exp_pc + 32'h4;
      end
      prev_stall = obs_req_valid && !imem_req_ready;
      prev_addr  = obs_req_addr;
    end
    resp_hold = 1'b0;
    n_tests++; if (n_cons < 200) begin n_fail++; $display("FAIL rnd_progress: got %0d consumed expected >=200", n_cons); end
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    inst_ready = 1'b0; pc_src = 2'b00; target_br = '0; target_jalr = '0;
    @(negedge clk);
    test_reset();
    test_seq_run();
    test_backpressure();
    test_branch();
    test_jalr_same_cycle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
